// File: rtl/ball_pkg.sv
// Shared ball-pool types and default dimensions for the allocator and ball controllers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ball_pkg;

    localparam int NUM_BALLS     = 8;
    localparam int SIZE_W        = 2;
    localparam int COORD_W       = 11;
    localparam int MAX_BALL_SIZE = (1 << SIZE_W) - 1;

    // Allocator sequencing: one pass per hit, spawn children one per cycle
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_REMOVE  = 3'd2,
        S_SPAWN_L = 3'd3,
        S_SPAWN_R = 3'd4,
        S_CHECK   = 3'd5
    } alloc_st_t;

endpackage

// File: rtl/lowest_set_finder.sv
// Priority encoder: index of the lowest set bit of vec, plus a found flag.
// Latency: purely combinational.
// Backpressure: none; found=0 leaves idx at 0.
module lowest_set_finder #(
    parameter int WIDTH = 8,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan from the top down so the lowest set bit is the last to win
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ball_slot_allocator.sv
// Ball pool scheduler: serialises hits, retires the struck ball and spawns two smaller children.
// Latency: ack 1 cycle after IDLE samples a hit, child spawns on the next two cycles (4-cycle pass, 3 for size 0).
// Backpressure: hitReq is held by the requester until its hitAck; requests on inactive slots are never acked.
module ball_slot_allocator #(
    parameter int NUM_BALLS = ball_pkg::NUM_BALLS,
    parameter int SIZE_W    = ball_pkg::SIZE_W,
    parameter int COORD_W   = ball_pkg::COORD_W
) (
    input  logic                           clk,
    input  logic                           resetN,
    input  logic                           levelStart,
    input  logic [SIZE_W-1:0]              levelSize,
    input  logic [COORD_W-1:0]             levelX,
    input  logic [COORD_W-1:0]             levelY,
    input  logic [NUM_BALLS-1:0]           hitReq,
    input  logic [NUM_BALLS*COORD_W-1:0]   ballX,
    input  logic [NUM_BALLS*COORD_W-1:0]   ballY,
    output logic [NUM_BALLS-1:0]           hitAck,
    output logic [NUM_BALLS-1:0]           available,
    output logic [NUM_BALLS*SIZE_W-1:0]    ballSize,
    output logic [NUM_BALLS-1:0]           spawnPulse,
    output logic [COORD_W-1:0]             spawnX,
    output logic [COORD_W-1:0]             spawnY,
    output logic                           spawnDirRight,
    output logic                           levelClear,
    output logic                           overflow
);

    import ball_pkg::*;

    localparam int IDX_W = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;

    alloc_st_t              state,      nxtState;
    logic [IDX_W-1:0]       hitIdx,     nxtHitIdx;
    logic [COORD_W-1:0]     hitX,       nxtHitX;
    logic [COORD_W-1:0]     hitY,       nxtHitY;
    logic [SIZE_W-1:0]      hitSize,    nxtHitSize;
    logic [SIZE_W-1:0]      sizeR       [NUM_BALLS];
    logic [SIZE_W-1:0]      nxtSize     [NUM_BALLS];
    logic [NUM_BALLS-1:0]   nxtAvailable;
    logic [NUM_BALLS-1:0]   nxtHitAck;
    logic [NUM_BALLS-1:0]   nxtSpawnPulse;
    logic [COORD_W-1:0]     nxtSpawnX;
    logic [COORD_W-1:0]     nxtSpawnY;
    logic                   nxtSpawnDirRight;
    logic                   nxtLevelClear;
    logic                   nxtOverflow;

    logic [COORD_W-1:0]     ballXArr    [NUM_BALLS];
    logic [COORD_W-1:0]     ballYArr    [NUM_BALLS];
    logic [NUM_BALLS-1:0]   hitCand;
    logic [IDX_W-1:0]       hitSel;
    logic                   hitFound;
    logic [NUM_BALLS-1:0]   hitMask;
    logic [NUM_BALLS-1:0]   freeBase;
    logic [NUM_BALLS-1:0]   freeVec;
    logic [IDX_W-1:0]       freeIdx;
    logic                   freeFound;
    logic [SIZE_W-1:0]      childSize;

    // Unpack the flattened position buses and repack the size registers
    always_comb begin
        for (int i = 0; i < NUM_BALLS; i++) begin
            ballXArr[i]                    = ballX[i*COORD_W +: COORD_W];
            ballYArr[i]                    = ballY[i*COORD_W +: COORD_W];
            ballSize[i*SIZE_W +: SIZE_W]   = sizeR[i];
        end
    end

    assign hitCand   = hitReq & available;
    assign hitMask   = NUM_BALLS'(1) << hitIdx;
    // While leaving REMOVE the struck slot is already counted as free, so the
    // left child may reuse it in the same edge that retires the parent.
    assign freeBase  = (state == S_REMOVE) ? (available & ~hitMask) : available;
    assign freeVec   = ~freeBase;
    assign childSize = hitSize - SIZE_W'(1);

    lowest_set_finder #(
        .WIDTH (NUM_BALLS),
        .IDX_W (IDX_W)
    ) u_hit_finder (
        .vec   (hitCand),
        .idx   (hitSel),
        .found (hitFound)
    );

    lowest_set_finder #(
        .WIDTH (NUM_BALLS),
        .IDX_W (IDX_W)
    ) u_free_finder (
        .vec   (freeVec),
        .idx   (freeIdx),
        .found (freeFound)
    );

    // Next-state and next-output decode; outputs are computed for the state
    // being entered so every pulse is visible while that state is current.
    always_comb begin
        nxtState         = state;
        nxtHitIdx        = hitIdx;
        nxtHitX          = hitX;
        nxtHitY          = hitY;
        nxtHitSize       = hitSize;
        nxtSize          = sizeR;
        nxtAvailable     = available;
        nxtSpawnX        = spawnX;
        nxtSpawnY        = spawnY;
        nxtSpawnDirRight = spawnDirRight;
        nxtOverflow      = overflow;
        nxtHitAck        = '0;
        nxtSpawnPulse    = '0;
        nxtLevelClear    = 1'b0;

        if (levelStart) begin
            // New level overrides anything in flight, including an unacked hit
            nxtState         = S_INIT;
            nxtAvailable     = NUM_BALLS'(1);
            for (int i = 0; i < NUM_BALLS; i++) begin
                nxtSize[i] = '0;
            end
            nxtSize[0]       = levelSize;
            nxtSpawnPulse    = NUM_BALLS'(1);
            nxtSpawnX        = levelX;
            nxtSpawnY        = levelY;
            nxtSpawnDirRight = 1'b1;
            nxtOverflow      = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (hitFound) begin
                        nxtState   = S_REMOVE;
                        nxtHitIdx  = hitSel;
                        nxtHitX    = ballXArr[hitSel];
                        nxtHitY    = ballYArr[hitSel];
                        nxtHitSize = sizeR[hitSel];
                        nxtHitAck  = NUM_BALLS'(1) << hitSel;
                    end
                end
                S_INIT: begin
                    nxtState = S_IDLE;
                end
                S_REMOVE: begin
                    nxtAvailable = available & ~hitMask;
                    if (hitSize == '0) begin
                        nxtState      = S_CHECK;
                        nxtLevelClear = ((available & ~hitMask) == '0);
                    end else begin
                        nxtState         = S_SPAWN_L;
                        nxtSpawnDirRight = 1'b0;
                        if (freeFound) begin
                            nxtAvailable[freeIdx] = 1'b1;
                            nxtSize[freeIdx]      = childSize;
                            nxtSpawnPulse         = NUM_BALLS'(1) << freeIdx;
                            nxtSpawnX             = hitX;
                            nxtSpawnY             = hitY;
                        end else begin
                            nxtOverflow = 1'b1;
                        end
                    end
                end
                S_SPAWN_L: begin
                    nxtState         = S_SPAWN_R;
                    nxtSpawnDirRight = 1'b1;
                    if (freeFound) begin
                        nxtAvailable[freeIdx] = 1'b1;
                        nxtSize[freeIdx]      = childSize;
                        nxtSpawnPulse         = NUM_BALLS'(1) << freeIdx;
                        nxtSpawnX             = hitX;
                        nxtSpawnY             = hitY;
                    end else begin
                        nxtOverflow = 1'b1;
                    end
                end
                S_SPAWN_R: begin
                    nxtState = S_IDLE;
                end
                S_CHECK: begin
                    nxtState = S_IDLE;
                end
                default: begin
                    nxtState = S_IDLE;
                end
            endcase
        end
    end

    // State, latched hit context, slot table and registered outputs
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state         <= S_IDLE;
            hitIdx        <= '0;
            hitX          <= '0;
            hitY          <= '0;
            hitSize       <= '0;
            sizeR         <= '{default: '0};
            available     <= '0;
            hitAck        <= '0;
            spawnPulse    <= '0;
            spawnX        <= '0;
            spawnY        <= '0;
            spawnDirRight <= 1'b0;
            levelClear    <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            state         <= nxtState;
            hitIdx        <= nxtHitIdx;
            hitX          <= nxtHitX;
            hitY          <= nxtHitY;
            hitSize       <= nxtHitSize;
            sizeR         <= nxtSize;
            available     <= nxtAvailable;
            hitAck        <= nxtHitAck;
            spawnPulse    <= nxtSpawnPulse;
            spawnX        <= nxtSpawnX;
            spawnY        <= nxtSpawnY;
            spawnDirRight <= nxtSpawnDirRight;
            levelClear    <= nxtLevelClear;
            overflow      <= nxtOverflow;
        end
    end

endmodule

// File: tb/tb_ball_slot_allocator.sv
// Self-checking bench for ball_slot_allocator against a slot-table model of the pool.
// Latency: n/a.
// Backpressure: hitReq held until ack, then dropped.
module tb_ball_slot_allocator;

    localparam int NB = 8;
    localparam int SW = 3;
    localparam int CW = 11;

    logic               clk = 1'b0;
    logic               resetN;
    logic               levelStart;
    logic [SW-1:0]      levelSize;
    logic [CW-1:0]      levelX, levelY;
    logic [NB-1:0]      hitReq;
    logic [NB*CW-1:0]   ballX, ballY;
    logic [NB-1:0]      hitAck, available, spawnPulse;
    logic [NB*SW-1:0]   ballSize;
    logic [CW-1:0]      spawnX, spawnY;
    logic               spawnDirRight, levelClear, overflow;

    int nPass  = 0;
    int nTotal = 0;

    // Reference pool: which slots hold a ball and how big it is
    bit mActive [NB];
    int mSize   [NB];
    bit mOverflow;
    int bx [NB];
    int by [NB];
    int expSlot [$];
    bit expDir  [$];
    int expClear;

    ball_slot_allocator #(
        .NUM_BALLS (NB),
        .SIZE_W    (SW),
        .COORD_W   (CW)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .levelStart    (levelStart),
        .levelSize     (levelSize),
        .levelX        (levelX),
        .levelY        (levelY),
        .hitReq        (hitReq),
        .ballX         (ballX),
        .ballY         (ballY),
        .hitAck        (hitAck),
        .available     (available),
        .ballSize      (ballSize),
        .spawnPulse    (spawnPulse),
        .spawnX        (spawnX),
        .spawnY        (spawnY),
        .spawnDirRight (spawnDirRight),
        .levelClear    (levelClear),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTotal++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int lowest(input logic [NB-1:0] v);
        for (int i = 0; i < NB; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [NB-1:0] m_avail();
        logic [NB-1:0] r = '0;
        for (int i = 0; i < NB; i++) r[i] = mActive[i];
        return r;
    endfunction

    function automatic logic [NB*SW-1:0] m_sizes();
        logic [NB*SW-1:0] r = '0;
        for (int i = 0; i < NB; i++) if (mActive[i]) r[i*SW +: SW] = SW'(mSize[i]);
        return r;
    endfunction

    // Sizes of inactive slots are don't-care, so mask them with the model's view
    function automatic logic [NB*SW-1:0] dut_sizes();
        logic [NB*SW-1:0] r = '0;
        for (int i = 0; i < NB; i++) if (mActive[i]) r[i*SW +: SW] = ballSize[i*SW +: SW];
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NB; i++) begin mActive[i] = 1'b0; mSize[i] = 0; end
        mOverflow = 1'b0;
    endtask

    task automatic model_init(input int sz);
        model_clear();
        mActive[0] = 1'b1;
        mSize[0]   = sz;
    endtask

    // A hit frees the slot, then each child takes the lowest free slot in turn
    task automatic model_hit(input int h);
        int sz;
        int f;
        expSlot.delete();
        expDir.delete();
        sz = mSize[h];
        mActive[h] = 1'b0;
        expClear = 0;
        if (sz == 0) begin
            if (m_avail() == '0) expClear = 1;
        end else begin
            for (int d = 0; d < 2; d++) begin
                f = lowest(~m_avail());
                if (f < 0) mOverflow = 1'b1;
                else begin
                    mActive[f] = 1'b1;
                    mSize[f]   = sz - 1;
                    expSlot.push_back(f);
                    expDir.push_back(d == 1);
                end
            end
        end
    endtask

    task automatic set_balls();
        for (int i = 0; i < NB; i++) begin
            bx[i] = $urandom_range(0, 2047);
            by[i] = $urandom_range(0, 2047);
            ballX[i*CW +: CW] = CW'(bx[i]);
            ballY[i*CW +: CW] = CW'(by[i]);
        end
    endtask

    task automatic check_state(input string pfx);
        chk({pfx, "_available"}, available, m_avail());
        chk({pfx, "_sizes"}, dut_sizes(), m_sizes());
        chk({pfx, "_overflow"}, overflow, mOverflow);
    endtask

    task automatic level_start(input int sz, input int x, input int y);
        levelStart = 1'b1;
        levelSize  = SW'(sz);
        levelX     = CW'(x);
        levelY     = CW'(y);
        @(negedge clk);
        levelStart = 1'b0;
        model_init(sz);
        chk("init_pulse", spawnPulse, 1);
        chk("init_x", spawnX, x);
        chk("init_y", spawnY, y);
        chk("init_dir", spawnDirRight, 1);
        check_state("init");
        @(negedge clk);
        chk("init_pulse_width", spawnPulse, 0);
    endtask

    // Wait for the ack of the lowest live request, then watch the two spawn slots
    task automatic service();
        logic [NB-1:0] expAck;
        int h, n, clr;
        int oS [$];
        bit oD [$];
        h = lowest(hitReq & m_avail());
        expAck = '0;
        expAck[h] = 1'b1;
        n = 0;
        while (hitAck == '0 && n < 12) begin @(negedge clk); n++; end
        chk("hit_ack", hitAck, expAck);
        hitReq[h] = 1'b0;
        model_hit(h);
        clr = 0;
        repeat (2) begin
            @(negedge clk);
            chk("ack_width", hitAck, 0);
            if (levelClear) clr++;
            if (spawnPulse != '0) begin
                oS.push_back(lowest(spawnPulse));
                oD.push_back(spawnDirRight);
                chk("spawn_onehot", $onehot(spawnPulse), 1);
                chk("spawn_x", spawnX, bx[h]);
                chk("spawn_y", spawnY, by[h]);
            end
        end
        chk("spawn_count", oS.size(), expSlot.size());
        for (int k = 0; k < oS.size() && k < expSlot.size(); k++) begin
            chk("spawn_slot", oS[k], expSlot[k]);
            chk("spawn_dir", oD[k], expDir[k]);
        end
        chk("level_clear", clr, expClear);
        check_state("hit");
        @(negedge clk);
    endtask

    task automatic hit_mask(input logic [NB-1:0] mask);
        int a;
        set_balls();
        hitReq = mask;
        while ((hitReq & m_avail()) != '0) service();
        a = 0;
        repeat (5) begin
            @(negedge clk);
            if (hitAck != '0) a++;
        end
        chk("no_spurious_ack", a, 0);
        hitReq = '0;
    endtask

    initial begin
        logic [NB-1:0] m;
        int s, best, n;
        resetN     = 1'b0;
        levelStart = 1'b0;
        levelSize  = '0;
        levelX     = '0;
        levelY     = '0;
        hitReq     = '0;
        ballX      = '0;
        ballY      = '0;
        model_clear();

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_available", available, 0);
        chk("rst_sizes", ballSize, 0);
        chk("rst_spawn", spawnPulse, 0);
        chk("rst_ack", hitAck, 0);
        chk("rst_clear", levelClear, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_xy", {spawnX, spawnY, spawnDirRight}, 0);
        resetN = 1'b1;
        @(negedge clk);
        chk("idle_available", available, 0);

        // First level, a single split, a simultaneous pair, an inactive request
        level_start(2, 100, 50);
        hit_mask(8'h01);
        hit_mask(8'h03);
        hit_mask(8'h80);
        // Remove all size-0 balls; the last one clears the level
        hit_mask(8'h0F);
        chk("all_cleared", available, 0);

        // levelStart together with a hit in IDLE: INIT wins, no ack
        level_start(1, 10, 20);
        hitReq     = 8'h01;
        levelStart = 1'b1;
        levelSize  = 3'd2;
        levelX     = 11'd33;
        levelY     = 11'd44;
        @(negedge clk);
        levelStart = 1'b0;
        hitReq     = '0;
        model_init(2);
        chk("ls_hit_noack", hitAck, 0);
        chk("ls_hit_init", spawnPulse, 1);
        check_state("ls_hit");
        @(negedge clk);
        chk("ls_hit_noack2", hitAck, 0);
        repeat (2) @(negedge clk);

        // levelStart while the left child is being spawned
        level_start(2, 100, 50);
        hitReq = 8'h01;
        n = 0;
        while (hitAck == '0 && n < 12) begin @(negedge clk); n++; end
        chk("mid_ack", hitAck, 1);
        hitReq = '0;
        @(negedge clk);
        chk("mid_spawnL", spawnPulse, 1);
        chk("mid_dirL", spawnDirRight, 0);
        levelStart = 1'b1;
        levelSize  = 3'd3;
        levelX     = 11'd7;
        levelY     = 11'd9;
        @(negedge clk);
        levelStart = 1'b0;
        model_init(3);
        chk("mid_init_pulse", spawnPulse, 1);
        chk("mid_init_x", spawnX, 7);
        chk("mid_init_dir", spawnDirRight, 1);
        check_state("mid_init");
        @(negedge clk);
        chk("mid_no_spawnR", spawnPulse, 0);
        chk("mid_avail", available, 1);

        // Grow the pool to all eight slots, then split once more
        level_start(4, 300, 200);
        repeat (7) begin
            best = -1;
            for (int i = 0; i < NB; i++)
                if (mActive[i] && (best < 0 || mSize[i] > mSize[best])) best = i;
            m = '0;
            m[best] = 1'b1;
            hit_mask(m);
        end
        chk("pool_full", available, 8'hFF);
        m = '0;
        m[lowest(m_avail())] = 1'b1;
        hit_mask(m);
        chk("overflow_set", overflow, 1);
        hit_mask(8'h80);
        chk("overflow_sticky", overflow, 1);
        level_start(1, 5, 5);
        chk("overflow_cleared", overflow, 0);

        // Randomised levels and hit patterns
        for (int lv = 0; lv < 4; lv++) begin
            level_start($urandom_range(1, 7), $urandom_range(0, 2047), $urandom_range(0, 2047));
            for (int it = 0; it < 16; it++) begin
                if (m_avail() != '0) begin
                    m = '0;
                    for (int i = 0; i < NB; i++)
                        if (mActive[i] && $urandom_range(0, 2) == 0) m[i] = 1'b1;
                    if (m == '0) begin
                        s = $urandom_range(0, NB - 1);
                        for (int j = 0; j < NB; j++)
                            if (m == '0 && mActive[(s + j) % NB]) m[(s + j) % NB] = 1'b1;
                    end
                    if ($urandom_range(0, 3) == 0) m[$urandom_range(0, NB - 1)] = 1'b1;
                    hit_mask(m);
                end
            end
        end

        // Asynchronous reset in the middle of a split
        level_start(3, 400, 100);
        hitReq = 8'h01;
        n = 0;
        while (hitAck == '0 && n < 12) begin @(negedge clk); n++; end
        chk("arst_ack", hitAck, 1);
        hitReq = '0;
        @(negedge clk);
        resetN = 1'b0;
        #1;
        chk("arst_available", available, 0);
        chk("arst_sizes", ballSize, 0);
        chk("arst_spawn", spawnPulse, 0);
        chk("arst_ack0", hitAck, 0);
        chk("arst_xy", {spawnX, spawnY, spawnDirRight}, 0);
        chk("arst_flags", {levelClear, overflow}, 0);
        @(negedge clk);
        resetN = 1'b1;
        model_clear();
        @(negedge clk);
        chk("arst_after_avail", available, 0);
        chk("arst_after_spawn", spawnPulse, 0);

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule

// File: doc/ball_slot_allocator.md
# ball_slot_allocator

Central scheduler for the Bubble Trouble ball pool. Owns `NUM_BALLS` ball slots: which are active, their size, and when each slot's ball instance is (re)loaded. Serialises simultaneous hit requests from the rope/player collision logic, one per pass. On each hit it retires the struck ball and spawns two smaller children at its position. Sits between the collision detector and the per-slot ball controllers/movers, and drives their `available` enables.

## Interface
Parameters:
- `NUM_BALLS`, 8: number of ball slots (≥2).
- `SIZE_W`, 2: ball size width. Size 0 is the smallest and is not split.
- `COORD_W`, 11: coordinate width for `topLeftX`/`topLeftY`.

Ports (clock and reset first):
- `clk`  in  1  system clock.
- `resetN`  in  1  asynchronous, active-low reset.
- `levelStart`  in  1  one-cycle pulse. Re-initialise the pool for a new level.
- `levelSize`  in  SIZE_W  size of the initial ball.
- `levelX`, `levelY`  in  COORD_W each  spawn position of the initial ball.
- `hitReq`  in  NUM_BALLS  level per slot. Held by the requester until the matching `hitAck`.
- `ballX`, `ballY`  in  NUM_BALLS*COORD_W each  current top-left position of every slot (flattened, slot 0 in the LSBs).
- `hitAck`  out  NUM_BALLS  one-cycle pulse acknowledging a hit.
- `available`  out  NUM_BALLS  slot-active mask.
- `ballSize`  out  NUM_BALLS*SIZE_W  size of each slot.
- `spawnPulse`  out  NUM_BALLS  one-cycle load strobe to a slot's ball controller.
- `spawnX`, `spawnY`  out  COORD_W each  load position, valid with `spawnPulse`.
- `spawnDirRight`  out  1  initial horizontal direction, valid with `spawnPulse`.
- `levelClear`  out  1  one-cycle pulse when the last ball is removed.
- `overflow`  out  1  sticky. A child was dropped because no slot was free.

## Operation
- States: `S_IDLE`, `S_INIT`, `S_REMOVE`, `S_SPAWN_L`, `S_SPAWN_R`, `S_CHECK`.
- Reset value of every output, and of all slot registers, is 0. The state resets to `S_IDLE`.
- `levelStart` has top priority in every state: the in-flight hit is abandoned and the next state is `S_INIT`.
- `S_INIT`:
  - Clear all slots.
  - Activate slot 0 with `levelSize`.
  - Drive `spawnPulse[0]`, `spawnX/Y`=`levelX/Y`, `spawnDirRight`=1.
  - Clear `overflow`.
  - Next state `S_IDLE`.
- `S_IDLE`: if `hitReq & available` is non-zero, latch the lowest set index `h`, latch `ballX/Y[h]` and `ballSize[h]`, then go to `S_REMOVE`. `hitReq` on inactive slots is ignored and never acknowledged.
- `S_REMOVE`:
  - `hitAck[h]`=1.
  - Clear `available[h]` at the end of the cycle.
  - If the latched size is 0, go to `S_CHECK`; otherwise go to `S_SPAWN_L`.
- `S_SPAWN_L`:
  - Take the lowest free slot `f`. Slot `h` is free again, so `f` always exists.
  - Set `available[f]`=1 and `ballSize[f]`=size−1.
  - Drive `spawnPulse[f]`, the latched X/Y, and `spawnDirRight`=0.
  - Next state `S_SPAWN_R`.
- `S_SPAWN_R`: same as `S_SPAWN_L` with `spawnDirRight`=1. If no slot is free, set `overflow` and emit no pulse. Next state `S_IDLE`.
- `S_CHECK`: if `available`==0, pulse `levelClear`. Next state `S_IDLE`.
- Size arithmetic is unsigned. Size−1 is computed only for size ≥1, so it never wraps.

## Timing
- Cycle 0: `S_IDLE` samples the hit.
- Cycle 1: `S_REMOVE`, `hitAck` high.
- Cycle 2: `S_SPAWN_L` spawn.
- Cycle 3: `S_SPAWN_R` spawn, or `S_CHECK` when the hit ball was size 0.
- Throughput: one hit per 4 cycles (3 cycles for size 0), well within a frame.
- Simultaneous hits are serviced lowest index first, one per pass. The held `hitReq` bits are picked up on later `S_IDLE` visits.
- `hitReq` dropped before its ack: a hit already latched completes; one not yet latched is lost.
- `levelStart` arriving together with `hitReq` in `S_IDLE`: INIT wins, and no ack is given.
- `spawnPulse`, `hitAck`, `levelClear` are registered Moore outputs, never high for more than one cycle. At most one `spawnPulse` bit is set per cycle.
- Mid-operation `resetN` low: everything returns to reset values immediately (asynchronous).

## Structure
- Shared package `ball_pkg` holds:
  - the state enum `alloc_st_t`;
  - the constants `NUM_BALLS`, `SIZE_W`, `COORD_W`;
  - `MAX_BALL_SIZE`.
  
  The ball controllers import the same package.
- One sub-module, `lowest_set_finder` (parameterised width; outputs index and found flag), instantiated twice: once on `hitReq & available` for hit selection and once on `~available` for free-slot search.

## Test plan
- Reset, then `levelStart` with size 2 at (100,50) → `available`=0x01, `ballSize[0]`=2, `spawnPulse[0]` for 1 cycle with X=100, Y=50, dir=1.
- `hitReq[0]` held high → `hitAck[0]` 1 cycle later; slots 0 and 1 active at size 1; dir 0 then 1; both spawns at the latched position.
- `hitReq`=0x03 in the same cycle → slot 0 is serviced first and slot 1 follows in the next pass; each is acked exactly once.
- Hit the last size-0 ball → `available`=0, `levelClear` 1 cycle, no `spawnPulse`.
- Fill all 8 slots, then hit a size-1 ball → one child spawned, the second dropped, `overflow`=1 until the next `levelStart`.
- `levelStart` during `S_SPAWN_L`, and `resetN` low mid-split → clean INIT from all-inactive, respectively all outputs 0.
